multiplier_fp_arbiter: RTL

Round-robin arbiter that shares one `multiplier_fp` instance among `N` requesters in the sum-of-squared-error datapath. Each requester presents a 32-bit IEEE-754 operand pair. The arbiter issues the pair to the multiplier with a single-cycle `start` pulse, waits for `ready`, and returns the product with a one-cycle `done` pulse to the owning requester. A watchdog recovers from a multiplier that never answers.

---
 rtl/multiplier_fp_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multiplier_fp_arbiter.sv
// Round-robin arbiter that shares a single floating-point multiplier among N
// requesters. A winner's operand pair is issued with a one-cycle start pulse.
// The product comes back as a one-cycle done pulse to the owner. A watchdog
// aborts an operation the multiplier never answers.
//
// Handshake: requester i raises req_i[i] and holds it, with its operands
// stable, until it sees grant_o[i] (the acceptance pulse, operands captured).
// Later, done_o[i] pulses for one cycle and result_o carries that product;
// error_o pulses with done_o when the operation was aborted by the watchdog.
module multiplier_fp_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N-1:0]    req_i,
  input  logic [32*N-1:0] req_a_i,
  input  logic [32*N-1:0] req_b_i,
  output logic [N-1:0]    grant_o,
  output logic [N-1:0]    done_o,
  output logic [31:0]     result_o,
  output logic            error_o,
  output logic            busy_o,
  output logic            m_start_o,
  output logic [31:0]     m_a_o,
  output logic [31:0]     m_b_o,
  input  logic            m_ready_i,
  input  logic            m_busy_i,
  input  logic [31:0]     m_y_i,
  output logic            dbg_state_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ABORT_VALUE = 32'h7F80_0001;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q, done_d;
  logic [31:0]     result_q, result_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;
  logic            m_start_q, m_start_d;
  logic [31:0]     m_a_q, m_a_d;
  logic [31:0]     m_b_q, m_b_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            mult_idle;

  // The multiplier has no reset, so it may still be finishing an operation
  // from before our reset; never issue while it is busy or answering.
  assign mult_idle = !m_busy_i && !m_ready_i;

  // Round-robin search starting just after the last-served requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        sel_a = req_a_i[32*i +: 32];
        sel_b = req_b_i[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    grant_d   = '0;
    done_d    = '0;
    result_d  = result_q;
    error_d   = 1'b0;
    m_start_d = 1'b0;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    case (state_q)
      S_IDLE: begin
        if (found && mult_idle) begin
          m_a_d          = sel_a;
          m_b_d          = sel_b;
          m_start_d      = 1'b1;
          grant_d[win]   = 1'b1;
          owner_d        = win;
          timer_d        = '0;
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (m_ready_i) begin
          result_d         = m_y_i;
          done_d[owner_q]  = 1'b1;
          ptr_d            = owner_q;
          state_d          = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Watchdog abort: report a NaN-pattern result flagged by error.
          result_d         = ABORT_VALUE;
          done_d[owner_q]  = 1'b1;
          error_d          = 1'b1;
          ptr_d            = owner_q;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(N - 1);
      owner_q   <= '0;
      timer_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      result_q  <= result_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      m_start_q <= m_start_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign error_o     = error_q;
  assign busy_o      = busy_q;
  assign m_start_o   = m_start_q;
  assign m_a_o       = m_a_q;
  assign m_b_o       = m_b_q;
  assign dbg_state_o = state_q;

endmodule
